// File: rtl/apb_req_arbiter_if.sv
// APB4 master-side bus bundle for the two-port request arbiter.
// The master drives the request phases; the slave returns ready/data/error.
interface apb_req_arbiter_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STROBE_WIDTH = 4,
    parameter int SLAVES_NUM   = 2
);
    logic [SLAVES_NUM-1:0]   PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [STROBE_WIDTH-1:0] PSTRB;
    logic [2:0]              PPROT;
    logic                    PREADY;
    logic                    PSLVERR;
    logic [DATA_WIDTH-1:0]   PRDATA;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PREADY, PSLVERR, PRDATA
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin two-requester arbiter driving APB4 SETUP/ACCESS phases,
// with invalid-select rejection and an ACCESS-phase timeout.
module apb_req_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int STROBE_WIDTH   = 4,
    parameter int SLAVES_NUM     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [1:0]                req_valid,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    input  logic [1:0]                req_write,
    input  logic [2*STROBE_WIDTH-1:0] req_strb,
    input  logic [5:0]                req_prot,
    input  logic [2*SLAVES_NUM-1:0]   req_sel,
    output logic [1:0]                req_done,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    apb_req_arbiter_if.master         apb
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    owner_q, owner_d;
    logic [SLAVES_NUM-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STROBE_WIDTH-1:0] pstrb_q, pstrb_d;
    logic [2:0]              pprot_q, pprot_d;
    logic [1:0]              done_q, done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [CW-1:0]           tcnt_q, tcnt_d;

    logic                    gnt;
    logic                    sel_ok;
    logic [SLAVES_NUM-1:0]   g_sel;
    logic [ADDR_WIDTH-1:0]   g_addr;
    logic [DATA_WIDTH-1:0]   g_wdata;
    logic                    g_write;
    logic [STROBE_WIDTH-1:0] g_strb;
    logic [2:0]              g_prot;

    // Contention goes to the requester not granted last.
    always_comb begin
        gnt     = (&req_valid) ? ~last_q : req_valid[1];
        g_sel   = gnt ? req_sel[2*SLAVES_NUM-1:SLAVES_NUM]
                      : req_sel[SLAVES_NUM-1:0];
        g_addr  = gnt ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                      : req_addr[ADDR_WIDTH-1:0];
        g_wdata = gnt ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                      : req_wdata[DATA_WIDTH-1:0];
        g_strb  = gnt ? req_strb[2*STROBE_WIDTH-1:STROBE_WIDTH]
                      : req_strb[STROBE_WIDTH-1:0];
        g_prot  = gnt ? req_prot[5:3] : req_prot[2:0];
        g_write = gnt ? req_write[1] : req_write[0];
        sel_ok  = (g_sel != '0) &&
                  ((g_sel & (g_sel - SLAVES_NUM'(1))) == '0);
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        done_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        tcnt_d    = tcnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    last_d  = gnt;
                    owner_d = gnt;
                    if (sel_ok) begin
                        state_d  = SETUP;
                        psel_d   = g_sel;
                        paddr_d  = g_addr;
                        pwdata_d = g_wdata;
                        pwrite_d = g_write;
                        pstrb_d  = g_write ? g_strb : '0;
                        pprot_d  = g_prot;
                    end else begin
                        state_d = DONE;
                        done_d  = gnt ? 2'b10 : 2'b01;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                tcnt_d    = '0;
            end
            ACCESS: begin
                tcnt_d = tcnt_q + CW'(1);
                // A ready in the last allowed cycle still completes normally.
                if (apb.PREADY) begin
                    state_d   = DONE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    done_d    = owner_q ? 2'b10 : 2'b01;
                    err_d     = apb.PSLVERR;
                    rdata_d   = pwrite_q ? '0 : apb.PRDATA;
                end else if (tcnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = DONE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    done_d    = owner_q ? 2'b10 : 2'b01;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PSTRB   = pstrb_q;
    assign apb.PPROT   = pprot_q;
    assign req_done    = done_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: table of single transfers plus
// round-robin, back-to-back spacing and mid-transfer reset sequences.
module tb_apb_req_arbiter;

    logic        CLK;
    logic        RST;
    logic [1:0]  req_valid;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_write;
    logic [7:0]  req_strb;
    logic [5:0]  req_prot;
    logic [3:0]  req_sel;
    logic [1:0]  req_done;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          slv_wait;
    logic [31:0] slv_rdata;
    logic        slv_err;
    int          acc_cnt;

    int n_tests;
    int n_fail;

    apb_req_arbiter_if #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .STROBE_WIDTH(4), .SLAVES_NUM(2)
    ) bus ();

    apb_req_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .STROBE_WIDTH(4),
        .SLAVES_NUM(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_write(req_write),
        .req_strb(req_strb), .req_prot(req_prot),
        .req_sel(req_sel), .req_done(req_done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Slave: ready after slv_wait stalled ACCESS cycles.
    always @(posedge CLK) acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;
    assign bus.PREADY  = bus.PENABLE && (acc_cnt >= slv_wait);
    assign bus.PRDATA  = slv_rdata;
    assign bus.PSLVERR = slv_err;

    typedef struct {
        int          r;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [1:0]  sel;
        int          wait_n;
        logic [31:0] prdata;
        logic        slverr;
        int          exp_lat;
        int          exp_acc;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_psel;
        logic [3:0]  exp_pstrb;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input logic [2:0] prot,
                           input logic [1:0] sel);
        req_addr[r*32 +: 32] = addr;
        req_wdata[r*32 +: 32] = wd;
        req_write[r] = wr;
        req_strb[r*4 +: 4] = strb;
        req_prot[r*3 +: 3] = prot;
        req_sel[r*2 +: 2] = sel;
    endtask

    task automatic xfer(input vec_t v, input int idx);
        int   cyc, acc, setup, perr;
        logic prev_sel, got, wr_seen;
        logic [1:0]  pseen;
        logic [3:0]  strb_seen;
        logic [31:0] addr_seen;
        string t;
        t = $sformatf("v%0d", idx);
        set_req(v.r, v.wr, v.addr, v.wdata, v.strb, v.prot, v.sel);
        slv_wait = v.wait_n;
        slv_rdata = v.prdata;
        slv_err = v.slverr;
        req_valid[v.r] = 1'b1;
        cyc = 0; acc = 0; setup = 0; perr = 0;
        prev_sel = 1'b0; got = 1'b0; wr_seen = 1'b0;
        pseen = '0; strb_seen = '0; addr_seen = '0;
        while (cyc < 100 && !got) begin
            @(posedge CLK); #1;
            cyc++;
            if (bus.PENABLE) begin
                acc++;
                if (!prev_sel) perr++;
            end else if (bus.PSEL != 0) begin
                setup++;
                strb_seen = bus.PSTRB;
                addr_seen = bus.PADDR;
                wr_seen = bus.PWRITE;
            end
            pseen = pseen | bus.PSEL;
            prev_sel = (bus.PSEL != 0);
            if (req_done != 0) got = 1'b1;
        end
        check({t, " done"}, req_done, (v.r == 1) ? 2'b10 : 2'b01);
        check({t, " latency"}, cyc, v.exp_lat);
        check({t, " access_cycles"}, acc, v.exp_acc);
        check({t, " setup_cycles"}, setup, (v.exp_psel != 0) ? 1 : 0);
        check({t, " err"}, rsp_err, v.exp_err);
        check({t, " rdata"}, rsp_rdata, v.exp_rdata);
        check({t, " psel"}, pseen, v.exp_psel);
        check({t, " idle_at_done"}, {bus.PSEL, bus.PENABLE}, 3'b000);
        check({t, " penable_order"}, perr, 0);
        if (v.exp_psel != 0) begin
            check({t, " pstrb"}, strb_seen, v.exp_pstrb);
            check({t, " paddr"}, addr_seen, v.addr);
            check({t, " pwrite"}, wr_seen, v.wr);
        end
        req_valid[v.r] = 1'b0;
        @(posedge CLK); #1;
        check({t, " done_pulse"}, req_done, 2'b00);
    endtask

    task automatic check_all_zero(input string t);
        check({t, " apb_ctl"},
              {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB, bus.PPROT},
              '0);
        check({t, " paddr_pwdata"}, {bus.PADDR, bus.PWDATA}, '0);
        check({t, " rsp"}, {req_done, rsp_err, rsp_rdata}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        int last_cyc;
        int n_done;
        logic [1:0] owners[4];
        logic [1:0] exp_own[4];
        n_tests = 0;
        n_fail = 0;
        // r wr addr wdata strb prot sel wait prdata slverr
        // lat acc err rdata psel pstrb
        vecs[0] = '{0, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 3'd0, 2'b01,
                    0, 32'h0, 1'b0, 3, 1, 1'b0, 32'h0, 2'b01, 4'hF};
        vecs[1] = '{1, 1'b0, 32'h20, 32'h1111_2222, 4'hF, 3'd2, 2'b10,
                    3, 32'h1234_5678, 1'b0, 6, 4, 1'b0, 32'h1234_5678,
                    2'b10, 4'h0};
        vecs[2] = '{0, 1'b0, 32'h30, 32'h0, 4'h3, 3'd1, 2'b01,
                    1000, 32'hDEAD_BEEF, 1'b0, 18, 16, 1'b1, 32'h0,
                    2'b01, 4'h0};
        vecs[3] = '{1, 1'b0, 32'h34, 32'h0, 4'h0, 3'd5, 2'b10,
                    15, 32'h0BAD_F00D, 1'b0, 18, 16, 1'b0, 32'h0BAD_F00D,
                    2'b10, 4'h0};
        vecs[4] = '{0, 1'b1, 32'h44, 32'h5555_AAAA, 4'hF, 3'd0, 2'b00,
                    0, 32'h7777_7777, 1'b0, 1, 0, 1'b1, 32'h0,
                    2'b00, 4'h0};
        vecs[5] = '{1, 1'b0, 32'h48, 32'h0, 4'h0, 3'd0, 2'b11,
                    0, 32'h7777_7777, 1'b0, 1, 0, 1'b1, 32'h0,
                    2'b00, 4'h0};
        vecs[6] = '{0, 1'b1, 32'h50, 32'hCAFE_0000, 4'hC, 3'd3, 2'b10,
                    0, 32'h9999_9999, 1'b1, 3, 1, 1'b1, 32'h0,
                    2'b10, 4'hC};
        vecs[7] = '{1, 1'b1, 32'h54, 32'h0000_BEEF, 4'h5, 3'd7, 2'b01,
                    2, 32'h0000_FFFF, 1'b0, 5, 3, 1'b0, 32'h0,
                    2'b01, 4'h5};

        RST = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_wdata = '0;
        req_write = '0;
        req_strb = '0;
        req_prot = '0;
        req_sel = '0;
        slv_wait = 0;
        slv_rdata = '0;
        slv_err = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 8; i++) xfer(vecs[i], i);

        // Contention from reset: grants alternate starting at requester 0.
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        set_req(0, 1'b1, 32'h100, 32'h1, 4'hF, 3'd0, 2'b01);
        set_req(1, 1'b1, 32'h200, 32'h2, 4'hF, 3'd0, 2'b10);
        slv_wait = 0;
        slv_err = 1'b0;
        req_valid = 2'b11;
        exp_own = '{2'b01, 2'b10, 2'b01, 2'b10};
        cyc = 0;
        last_cyc = 0;
        n_done = 0;
        while (cyc < 40 && n_done < 4) begin
            @(posedge CLK); #1;
            cyc++;
            if (req_done != 0) begin
                owners[n_done] = req_done;
                if (n_done > 0)
                    check($sformatf("rr spacing%0d", n_done),
                          cyc - last_cyc, 4);
                last_cyc = cyc;
                n_done++;
            end
        end
        req_valid = 2'b00;
        check("rr done_count", n_done, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < n_done)
                check($sformatf("rr owner%0d", k), owners[k], exp_own[k]);
        end
        repeat (2) @(posedge CLK);
        #1;

        // Reset during ACCESS abandons the transfer; the held request reruns.
        set_req(0, 1'b0, 32'h400, 32'h0, 4'hF, 3'd1, 2'b01);
        slv_wait = 1000;
        slv_rdata = 32'h0;
        req_valid = 2'b01;
        cyc = 0;
        while (cyc < 10 && !bus.PENABLE) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("rst reached_access", bus.PENABLE, 1'b1);
        RST = 1'b0;
        #1;
        check_all_zero("rst_mid");
        n_done = 0;
        repeat (2) begin
            @(posedge CLK); #1;
            if (req_done != 0) n_done++;
        end
        check("rst no_done", n_done, 0);
        slv_wait = 0;
        slv_rdata = 32'hCAFE_0001;
        RST = 1'b1;
        cyc = 0;
        while (cyc < 10 && req_done == 0) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("rst reissue_done", req_done, 2'b01);
        check("rst reissue_latency", cyc, 3);
        check("rst reissue_err", rsp_err, 1'b0);
        check("rst reissue_rdata", rsp_rdata, 32'hCAFE_0001);
        req_valid = 2'b00;
        repeat (2) @(posedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-port request arbiter and APB4 transfer sequencer placed in front of the GPIO/UART APB slave fabric. It accepts transfer requests from two independent requesters, selects one per transfer with round-robin fairness, and drives the SETUP/ACCESS phases on the APB bus. It returns read data and error status to the winning requester, and terminates hung transfers with a timeout error.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- STROBE_WIDTH, 4, write-strobe width (DATA_WIDTH/8)
- SLAVES_NUM, 2, number of APB slaves; one PSEL bit each
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY; must be ≥2

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request; held high with fields stable until that requester's req_done
- req_addr  in  2*ADDR_WIDTH  requester n uses slice n
- req_wdata  in  2*DATA_WIDTH  write data, slice n
- req_write  in  2  1 = write, 0 = read
- req_strb  in  2*STROBE_WIDTH  byte strobes, slice n
- req_prot  in  2*3  protection attributes, slice n
- req_sel  in  2*SLAVES_NUM  slave select, slice n; must be one-hot
- req_done  out  2  one-cycle pulse to the owning requester
- rsp_rdata  out  DATA_WIDTH  read data; valid while req_done is high
- rsp_err  out  1  error flag; valid while req_done is high
- PSEL  out  SLAVES_NUM  APB select
- PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  STROBE_WIDTH  APB write strobes
- PPROT  out  3  APB protection attributes
- PREADY, PSLVERR  in  1 each  APB slave response
- PRDATA  in  DATA_WIDTH  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- **IDLE**
  - If no req_valid is high, the FSM stays in IDLE.
  - If any req_valid is high, the FSM grants one requester and latches that requester's fields.
  - Round-robin rule: when both requesters are valid, grant the one not granted last. The last-grant pointer updates on every grant.
  - If the latched req_sel is one-hot, go to SETUP.
  - If the latched req_sel is zero or has multiple bits set, go straight to DONE with err=1 and rdata=0. No APB activity occurs.
- **SETUP**
  - PSEL = latched sel, PENABLE = 0.
  - PADDR, PWRITE, PPROT, PWDATA are driven from the latched fields.
  - PSTRB = latched strb on writes; PSTRB = 0 on reads.
  - Always go to ACCESS next.
- **ACCESS**
  - PENABLE = 1. All other APB outputs hold their SETUP values.
  - Timeout counter increments once per ACCESS cycle.
  - If PREADY = 1: capture PSLVERR into err. On reads, capture PRDATA into rdata; on writes, rdata = 0. Go to DONE.
  - Timeout: if PREADY is still 0 in the TIMEOUT_CYCLES-th ACCESS cycle, set err=1 and rdata=0, then go to DONE.
  - PREADY arriving in that final cycle takes precedence and completes normally.
- **DONE**
  - PSEL = 0, PENABLE = 0.
  - req_done[owner] = 1 for exactly one cycle; rsp_rdata and rsp_err are valid in this cycle.
  - Go to IDLE. The requester may drop or change req_valid at the edge that ends DONE.
- In IDLE, PADDR, PWDATA, PWRITE, PSTRB and PPROT hold their last values; PSEL and PENABLE are 0.
- rsp_rdata and rsp_err hold their values outside DONE. They have meaning only when req_done is high.
- A request that arrives while a transfer is in flight waits. Neither requester can be starved: at most one transfer from the other requester is served in between.

## Timing
- Reset (RST low, asynchronous):
  - State goes to IDLE; last-grant pointer = requester 1, so requester 0 wins the first contention.
  - All outputs = 0: PSEL, PENABLE, PADDR, PWDATA, PWRITE, PSTRB, PPROT, req_done, rsp_rdata, rsp_err.
  - Timeout counter = 0.
- Reset mid-transfer abandons the transfer without issuing req_done. After RST deasserts, a requester still holding req_valid is re-arbitrated normally.
- Zero-wait transfer, starting with req_valid sampled at edge 0:
  - SETUP visible after edge 1.
  - ACCESS visible after edge 2; PREADY is sampled high at edge 3.
  - DONE visible after edge 3.
  - IDLE at edge 4.
  - Request-to-done latency is 3 cycles; each wait state adds 1 cycle.
- Back-to-back transfers: minimum spacing is 4 cycles per transfer.
- Invalid sel: req_done is visible 1 cycle after the grant edge.
- Timeout: the transfer terminates after exactly TIMEOUT_CYCLES ACCESS cycles; req_done follows one cycle later.

## Test plan
- Reset, then requester 0 writes addr 0x0000_0010, data 0xA5A5_A5A5, strb 0xF, sel 01 with PREADY tied high -> one SETUP cycle and one ACCESS cycle with PSEL=01 and PWRITE=1; req_done=01 three cycles after the request; rsp_err=0.
- Requester 1 reads with sel 10; the slave holds PREADY low for 3 cycles, then returns PRDATA 0x1234_5678 -> 4 ACCESS cycles; PSTRB=0; req_done=10; rsp_rdata=0x1234_5678.
- Both requesters valid continuously after reset -> grants alternate 0,1,0,1. No APB transfer overlaps another. PSEL/PENABLE sequencing stays legal.
- PREADY held low permanently with TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then PSEL drops; req_done with rsp_err=1 and rsp_rdata=0. A second run with PREADY arriving in cycle 16 -> normal completion, rsp_err=0.
- req_sel = 00 and, separately, req_sel = 11 -> PSEL stays 0 throughout; req_done one cycle after the grant with rsp_err=1. PSLVERR=1 on a valid transfer -> rsp_err=1.
- RST pulsed low during ACCESS -> all outputs 0 immediately; no req_done for the abandoned transfer; the held request is reissued and completes after reset deasserts.
